// File: rtl/ap_ctrl_pkg.sv
// Shared types and default sizing for the ap_ctrl_chain initiator.
package ap_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2,
        ERR  = 2'd3
    } ap_ctrl_state_t;

    localparam int unsigned AP_CNT_W_DEF     = 16;
    localparam int unsigned AP_TIMEOUT_DEF   = 1024;
    localparam int unsigned AP_NUM_TRANS_DEF = 16;

endpackage

// File: rtl/ap_ctrl_watchdog.sv
// Quiet-cycle counter: counts armed cycles without a handshake and flags the
// TIMEOUT-th one so the caller's error register is high on that cycle.
module ap_ctrl_watchdog
    import ap_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = AP_TIMEOUT_DEF
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    input  logic arm,
    input  logic clear,
    output logic expire
);

    localparam int unsigned WD = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD-1:0] LAST = WD'(TIMEOUT - 2);

    logic [WD-1:0] cnt_q;
    logic [WD-1:0] cnt_d;

    // cnt_q holds the number of earlier quiet cycles in the current streak.
    assign expire = arm && !clear && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !arm) begin
            cnt_d = '0;
        end else if (!expire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ap_ctrl_driver.sv
// Block-level ap_ctrl_chain initiator: issues NUM_TRANS starts, acknowledges
// dones, raises a sticky finish, and flags hung or misbehaving kernels.
module ap_ctrl_driver
    import ap_ctrl_pkg::*;
#(
    parameter int unsigned NUM_TRANS = AP_NUM_TRANS_DEF,
    parameter int unsigned CNT_W     = AP_CNT_W_DEF,
    parameter int unsigned MAX_OUTST = 2,
    parameter int unsigned CONT_HOLD = 0,
    parameter int unsigned TIMEOUT   = AP_TIMEOUT_DEF
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             enable,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_idle,
    output logic             ap_continue,
    output logic [CNT_W-1:0] start_count,
    output logic [CNT_W-1:0] done_count,
    output logic             finish,
    output logic             timeout_err,
    output logic             proto_err,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] N_TRANS   = CNT_W'(NUM_TRANS);
    localparam logic [CNT_W-1:0] N_OUTST   = CNT_W'(MAX_OUTST);
    localparam int unsigned      HW        = (CONT_HOLD > 1) ? $clog2(CONT_HOLD + 1) : 1;
    localparam logic [HW-1:0]    HOLD_LOAD = HW'(CONT_HOLD);

    ap_ctrl_state_t   state_q, state_d;
    logic             start_q, start_d;
    logic             cont_q, cont_d;
    logic [CNT_W-1:0] start_cnt_q, start_cnt_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             finish_q, finish_d;
    logic             tmo_q, tmo_d;
    logic             proto_q, proto_d;

    logic             start_hs;
    logic             done_hs;
    logic [CNT_W-1:0] outst_q;
    logic [CNT_W-1:0] outst_d;
    logic             wd_arm;
    logic             wd_expire;

    assign start_hs = start_q && ap_ready;
    assign done_hs  = cont_q && ap_done;
    assign outst_q  = start_cnt_q - done_cnt_q;
    assign wd_arm   = (state_q == RUN) && (start_q || (outst_q != '0));

    ap_ctrl_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .arm      (wd_arm),
        .clear    (start_hs || done_hs),
        .expire   (wd_expire)
    );

    always_comb begin
        start_cnt_d = start_cnt_q;
        done_cnt_d  = done_cnt_q;
        if (start_hs && (start_cnt_q != CNT_MAX)) begin
            start_cnt_d = start_cnt_q + 1'b1;
        end
        if (done_hs && (done_cnt_q != CNT_MAX)) begin
            done_cnt_d = done_cnt_q + 1'b1;
        end
        outst_d = start_cnt_d - done_cnt_d;

        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN: begin
                if (wd_expire) begin
                    state_d = ERR;
                end else if (done_cnt_d >= N_TRANS) begin
                    state_d = FIN;
                end
            end
            default: state_d = state_q;
        endcase

        hold_d = hold_q;
        if (done_hs) begin
            hold_d = HOLD_LOAD;
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end

        // A pending request is held until ready; enable only gates new ones.
        start_d = (state_d == RUN) &&
                  ((start_q && !ap_ready) ||
                   (enable && (start_cnt_d < N_TRANS) && (outst_d < N_OUTST)));
        cont_d  = (state_d == RUN) && (hold_d == '0);

        finish_d = finish_q || (state_d == FIN);
        tmo_d    = tmo_q || wd_expire;
        proto_d  = proto_q ||
                   (done_hs && (outst_q == '0)) ||
                   (ap_ready && !start_q) ||
                   (ap_idle && (outst_q != '0) && !ap_done);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            cont_q      <= 1'b0;
            start_cnt_q <= '0;
            done_cnt_q  <= '0;
            hold_q      <= '0;
            finish_q    <= 1'b0;
            tmo_q       <= 1'b0;
            proto_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            cont_q      <= cont_d;
            start_cnt_q <= start_cnt_d;
            done_cnt_q  <= done_cnt_d;
            hold_q      <= hold_d;
            finish_q    <= finish_d;
            tmo_q       <= tmo_d;
            proto_q     <= proto_d;
        end
    end

    assign ap_start    = start_q;
    assign ap_continue = cont_q;
    assign start_count = start_cnt_q;
    assign done_count  = done_cnt_q;
    assign finish      = finish_q;
    assign timeout_err = tmo_q;
    assign proto_err   = proto_q;
    assign busy        = (state_q == RUN);

endmodule

// File: doc/ap_ctrl_driver.md
# ap_ctrl_driver

Synthesizable initiator for the HLS block-level `ap_ctrl_chain` handshake. It drives `ap_start` and `ap_continue` into a generated kernel and counts start and done handshakes. It raises a sticky `finish` once `NUM_TRANS` transactions have completed, which is the level the dataflow status monitor samples to end its capture. A watchdog and protocol checker flag hung or misbehaving kernels.

## Interface
- `NUM_TRANS`, 16: total transactions to issue and retire; range 1 to 2^CNT_W−1.
- `CNT_W`, 16: width of all counters.
- `MAX_OUTST`, 2: maximum started-but-not-done transactions; at least 1.
- `CONT_HOLD`, 0: cycles `ap_continue` is held low after each accepted done. 0 means it is always high while running.
- `TIMEOUT`, 1024: cycles with no handshake before the error; at least 2.
- `ap_clk` in 1: the single clock.
- `ap_rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: level; arms the run from IDLE and gates new start assertions.
- `ap_start` out 1: kernel start request.
- `ap_ready` in 1: kernel accepted start.
- `ap_done` in 1: kernel completion, held by the kernel until `ap_continue`.
- `ap_idle` in 1: kernel idle; used only by the checker.
- `ap_continue` out 1: completion acknowledge.
- `start_count` out CNT_W: accepted starts.
- `done_count` out CNT_W: accepted dones.
- `finish` out 1: sticky; all transactions retired.
- `timeout_err` out 1: sticky watchdog error.
- `proto_err` out 1: sticky protocol violation.
- `busy` out 1: FSM is in RUN.

## Operation
- **FSM states:** IDLE, RUN, FIN, ERR.
  - IDLE→RUN when `enable` is high.
  - RUN→FIN when `done_count` reaches `NUM_TRANS`.
  - RUN→ERR on timeout.
  - FIN and ERR are left only by reset.
- **Start handshake:** a start fires on a cycle with `ap_start && ap_ready`; `start_count` increments.
- **Start request:** `ap_start` is asserted when all of the following hold:
  - state is RUN and `enable` is high;
  - `start_count < NUM_TRANS`;
  - `outstanding < MAX_OUTST`, where outstanding = `start_count − done_count`.
- **Start hold rule:** once `ap_start` is high it stays high until `ap_ready`, even if `enable` drops. Dropping `enable` only blocks new assertions.
- **Done handshake:** a done is accepted on a cycle with `ap_done && ap_continue`; `done_count` increments.
- **Continue policy:**
  - `ap_continue` is high in RUN.
  - After each accepted done it goes low for `CONT_HOLD` cycles, then returns high.
  - It is low in IDLE, FIN and ERR.
- **Simultaneous events:** a start and a done in the same cycle both count; outstanding is unchanged.
- **`proto_err` is set on any of:**
  - `ap_done` accepted while outstanding is 0;
  - `ap_ready` high while `ap_start` is low;
  - `ap_idle` high while outstanding > 0 and `ap_done` is low.
- **Effect of `proto_err`:** it is flag-only; the FSM keeps running.
- **Watchdog:**
  - Counts cycles in RUN while `ap_start` is high or outstanding > 0.
  - Clears on any start or done handshake.
  - At `TIMEOUT`: `timeout_err` is set, the FSM goes to ERR, and `ap_start` and `ap_continue` drop.
- **`finish`:** set on entry to FIN and held until reset.
- **Reset:** asynchronous; asserting `ap_rst_n` low mid-run returns the block to IDLE immediately.
- **Reset values:** all outputs are 0 and all counters are 0.

## Timing
- All outputs are registered, except `start_count`, `done_count`, `busy` and the flags, which are direct register reads.
- `enable` sampled high in IDLE gives `ap_start` high one cycle later.
- **Back-to-back starts:** if the conditions still hold at the ready cycle, `ap_start` remains high with no bubble. Otherwise it is low the next cycle.
- **Continue timing:** with `CONT_HOLD` = N > 0, `ap_continue` is low on cycles d+1 through d+N after a done accepted on cycle d, and high at d+N+1.
- **Finish timing:** `finish` rises one cycle after the done handshake that makes `done_count == NUM_TRANS`.
- **Timeout timing:** the `timeout_err` register rises on the `TIMEOUT`-th consecutive quiet cycle.
- **Counter width:** counters saturate at their maximum. `NUM_TRANS` below 2^CNT_W guarantees they never wrap during a legal run.

## Structure
- **Package `ap_ctrl_pkg`:** holds the state enum `ap_ctrl_state_t` (IDLE, RUN, FIN, ERR) and `localparam` defaults for the counter width and timeout.
- **Sub-module `ap_ctrl_watchdog`:** the cycle counter with clear, arm and expire signals, parameterized by `TIMEOUT`.
- **Top module:** the FSM, start/done counters, continue hold counter and checker live in `ap_ctrl_driver`.

## Test plan
- **Zero-latency kernel:** `NUM_TRANS`=4, `MAX_OUTST`=2, `CONT_HOLD`=0, kernel ready same cycle and done 3 cycles after start → `start_count` 4 and `done_count` 4; `finish` high one cycle after the 4th done; `ap_start` never high after the 4th ready.
- **Continue backpressure:** `CONT_HOLD`=2, single transaction → `ap_continue` low exactly 2 cycles after the done; the kernel holds `ap_done`; `done_count` increments once.
- **Outstanding limit:** `MAX_OUTST`=1 and ready asserted every cycle → `ap_start` drops after each ready until the matching done, so starts never exceed dones+1.
- **Hung kernel:** `TIMEOUT`=16 and `ap_ready` never asserted → `timeout_err` high on cycle 16 of RUN; state ERR; `ap_start` 0; `finish` 0.
- **Protocol and simultaneous events:** `ap_done` pulsed with 0 outstanding → `proto_err` sticky 1 while counts continue. Start and done in the same cycle → both counters +1.
- **Reset mid-run:** `ap_rst_n` low after 2 of 4 transactions → all outputs 0 immediately; after release with `enable` high, a fresh 4-transaction run completes with `finish` 1.
